param_sync_fifo: RTL

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_mem.sv | 26 ++
 rtl/param_sync_fifo.sv | 94 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and pointer-width helper.
// Thresholds and read mode stay local to each FIFO instance.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;

  // Address width for a power-of-two depth; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read address, no reset.
// Kept free of control logic so it can map onto distributed RAM.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AW         = ptr_w(DEF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered flags, sticky over/underflow, and either
// one-cycle read latency (FWFT=0) or a registered first-word-fall-through head.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     ren,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [ptr_w(DEPTH):0]    count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         rd_ptr_nxt;
  logic [AW-1:0]         mem_raddr;
  logic [CW-1:0]         count_nxt;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_acc;
  logic                  rd_acc;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_comb begin
    wr_acc     = wen & ~full;
    rd_acc     = ren & ~empty;
    rd_ptr_nxt = rd_acc ? rd_ptr + AW'(1) : rd_ptr;
    count_nxt  = count;
    if (wr_acc && !rd_acc)      count_nxt = count + CW'(1);
    else if (!wr_acc && rd_acc) count_nxt = count - CW'(1);
    // FWFT preloads the word that will be at the head after this edge.
    mem_raddr  = (FWFT != 0) ? rd_ptr_nxt : rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rdata        <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      full         <= (count_nxt == CW'(DEPTH));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CW'(AFULL_THRESH));
      almost_empty <= (count_nxt <= CW'(AEMPTY_THRESH));
      if (wen && full)  overflow  <= 1'b1;
      if (ren && empty) underflow <= 1'b1;
      if (FWFT == 0) begin
        if (rd_acc) rdata <= mem_rdata;
      end else if (count_nxt != '0) begin
        // New head is the word being written when the FIFO drains to it this edge.
        rdata <= (wr_acc && (wr_ptr == rd_ptr_nxt)) ? wdata : mem_rdata;
      end
    end
  end

endmodule
